// File: rtl/memory_access.sv
// MEM stage of the pipeline: drives the data-memory port, aligns store/load data and owns the MEM/WB register.
// Memory accesses stall upstream until dmem_ready; write-back appears one edge after the completing cycle.
module memory_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwriteM,
  input  logic        memrwM,
  input  logic [1:0]  wbselM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  rdM,
  input  logic [31:0] ALUresM,
  input  logic [31:0] data_writeM,
  input  logic [31:0] pc4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stallM,
  output logic        regwriteW,
  output logic [4:0]  rdW,
  output logic [31:0] resultW,
  output logic        misalignW
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        misalign_q, misalign_d;

  logic        is_load, is_store, misalign, access;
  logic [1:0]  off;
  logic [31:0] rdata_sh, load_data;

  assign off      = ALUresM[1:0];
  assign is_load  = (wbselM == 2'b00) && !memrwM;
  assign is_store = memrwM;

  // LHU only exists as a load encoding; funct3=101 on a store is just an unsupported size.
  always_comb begin
    misalign = 1'b0;
    if (is_load || is_store) begin
      case (funct3M)
        3'b001:  misalign = off[0];
        3'b101:  misalign = is_load && off[0];
        3'b010:  misalign = (off != 2'b00);
        default: misalign = 1'b0;
      endcase
    end
  end

  assign access = (is_load || is_store) && !misalign;

  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    stallM   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            stallM  = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) state_d = IDLE;
        else            stallM  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Reset must drop the request combinationally, even mid-access.
    if (!rst_n) begin
      dmem_req = 1'b0;
      stallM   = 1'b0;
      state_d  = IDLE;
    end
  end

  assign dmem_we   = dmem_req && memrwM;
  assign dmem_addr = {ALUresM[31:2], 2'b00};

  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = data_writeM;
    case (funct3M)
      3'b000: begin
        dmem_wstrb = 4'b0001 << off;
        dmem_wdata = {4{data_writeM[7:0]}};
      end
      3'b001: begin
        dmem_wstrb = 4'b0011 << off;
        dmem_wdata = {2{data_writeM[15:0]}};
      end
      3'b010:  dmem_wstrb = 4'b1111;
      default: dmem_wstrb = 4'b0000;
    endcase
  end

  assign rdata_sh = dmem_rdata >> {off, 3'b000};

  always_comb begin
    case (funct3M)
      3'b000:  load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b100:  load_data = {24'h0, rdata_sh[7:0]};
      3'b001:  load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  load_data = {16'h0, rdata_sh[15:0]};
      3'b010:  load_data = dmem_rdata;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = 5'd0;
    result_d   = 32'h0;
    misalign_d = 1'b0;
    if (!stallM) begin
      regwrite_d = regwriteM && !misalign;
      rd_d       = rdM;
      misalign_d = misalign;
      case (wbselM)
        2'b00:   result_d = load_data;
        2'b01:   result_d = ALUresM;
        2'b10:   result_d = pc4M;
        default: result_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      result_q   <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
    end
  end

  assign regwriteW = regwrite_q;
  assign rdW       = rd_q;
  assign resultW   = result_q;
  assign misalignW = misalign_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: W-stage expectations flow through a scoreboard queue.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwriteM, memrwM;
  logic [1:0]  wbselM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;
  logic [31:0] ALUresM, data_writeM, pc4M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        stallM, regwriteW, misalignW;
  logic [4:0]  rdW;
  logic [31:0] resultW;

  int vectors = 0;
  int miscompares = 0;
  logic [38:0] wq[$];

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .rst_n(rst_n),
    .regwriteM(regwriteM), .memrwM(memrwM), .wbselM(wbselM), .funct3M(funct3M), .rdM(rdM),
    .ALUresM(ALUresM), .data_writeM(data_writeM), .pc4M(pc4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stallM(stallM), .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .misalignW(misalignW)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] wrec(input logic mis, input logic rw, input logic [4:0] rd,
                                       input logic [31:0] res);
    return {mis, rw, rd, res};
  endfunction

  task automatic set_op(input logic rw, input logic mw, input logic [1:0] wb, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc4);
    regwriteM = rw; memrwM = mw; wbselM = wb; funct3M = f3;
    rdM = rd; ALUresM = alu; data_writeM = wd; pc4M = pc4;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle(input string tag, input logic exp_stall, input logic exp_req,
                       input logic [38:0] exp_w);
    #1;
    chk({tag, ".stallM"}, 64'(stallM), 64'(exp_stall));
    chk({tag, ".dmem_req"}, 64'(dmem_req), 64'(exp_req));
    wq.push_back(exp_w);
    @(posedge clk);
    #1;
    chk({tag, ".W"}, 64'({misalignW, regwriteW, rdW, resultW}), 64'(wq.pop_front()));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    set_op(1'b1, 1'b0, 2'b00, 3'b010, 5'd5, 32'h100, 32'h0, 32'h0);

    // Reset state while a load is presented
    @(negedge clk);
    #1;
    chk("rst.dmem_req", 64'(dmem_req), 64'd0);
    chk("rst.stallM", 64'(stallM), 64'd0);
    @(posedge clk);
    #1;
    chk("rst.W", 64'({misalignW, regwriteW, rdW, resultW}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait LW
    set_op(1'b1, 1'b0, 2'b00, 3'b010, 5'd5, 32'h100, 32'h0, 32'h0);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw.addr", 64'(dmem_addr), 64'h100);
    chk("lw.we", 64'(dmem_we), 64'd0);
    cycle("lw", 1'b0, 1'b1, wrec(1'b0, 1'b1, 5'd5, 32'hDEADBEEF));

    // LB at 0x103 with two wait states
    set_op(1'b1, 1'b0, 2'b00, 3'b000, 5'd6, 32'h103, 32'h0, 32'h0);
    dmem_ready = 1'b0; dmem_rdata = 32'h80000000;
    cycle("lb.w1", 1'b1, 1'b1, wrec(1'b0, 1'b0, 5'd0, 32'h0));
    chk("lb.addr", 64'(dmem_addr), 64'h100);
    cycle("lb.w2", 1'b1, 1'b1, wrec(1'b0, 1'b0, 5'd0, 32'h0));
    dmem_ready = 1'b1;
    cycle("lb.done", 1'b0, 1'b1, wrec(1'b0, 1'b1, 5'd6, 32'hFFFFFF80));

    // SH at 0x202
    set_op(1'b0, 1'b1, 2'b00, 3'b001, 5'd0, 32'h202, 32'h1234ABCD, 32'h0);
    dmem_ready = 1'b1; dmem_rdata = 32'h0;
    #1;
    chk("sh.wstrb", 64'(dmem_wstrb), 64'(4'b1100));
    chk("sh.wdata", 64'(dmem_wdata), 64'hABCDABCD);
    chk("sh.we", 64'(dmem_we), 64'd1);
    chk("sh.addr", 64'(dmem_addr), 64'h200);
    cycle("sh", 1'b0, 1'b1, wrec(1'b0, 1'b0, 5'd0, 32'h0));

    // SB at 0x201
    set_op(1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h201, 32'h00000055, 32'h0);
    #1;
    chk("sb.wstrb", 64'(dmem_wstrb), 64'(4'b0010));
    chk("sb.wdata", 64'(dmem_wdata), 64'h55555555);
    cycle("sb", 1'b0, 1'b1, wrec(1'b0, 1'b0, 5'd0, 32'h0));

    // Store with unsupported funct3: no strobes, handshake still happens
    set_op(1'b0, 1'b1, 2'b00, 3'b011, 5'd0, 32'h300, 32'hFFFFFFFF, 32'h0);
    #1;
    chk("sx.wstrb", 64'(dmem_wstrb), 64'd0);
    cycle("sx", 1'b0, 1'b1, wrec(1'b0, 1'b0, 5'd0, 32'h0));

    // Misaligned LW at 0x101, then ALU op (with stray ready), JAL, wbsel=11
    set_op(1'b1, 1'b0, 2'b00, 3'b010, 5'd7, 32'h101, 32'h0, 32'h0);
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    cycle("mis", 1'b0, 1'b0, wrec(1'b1, 1'b0, 5'd7, 32'h0));
    set_op(1'b1, 1'b0, 2'b01, 3'b000, 5'd3, 32'h7, 32'h0, 32'h0);
    dmem_ready = 1'b1;
    cycle("alu", 1'b0, 1'b0, wrec(1'b0, 1'b1, 5'd3, 32'h7));
    set_op(1'b1, 1'b0, 2'b10, 3'b000, 5'd1, 32'h1000, 32'h0, 32'h44);
    dmem_ready = 1'b0;
    cycle("jal", 1'b0, 1'b0, wrec(1'b0, 1'b1, 5'd1, 32'h44));
    set_op(1'b1, 1'b0, 2'b11, 3'b000, 5'd4, 32'h5, 32'h0, 32'h9);
    cycle("wb11", 1'b0, 1'b0, wrec(1'b0, 1'b1, 5'd4, 32'h0));

    // Reset during WAIT abandons the access
    set_op(1'b1, 1'b0, 2'b00, 3'b010, 5'd8, 32'h300, 32'h0, 32'h0);
    dmem_ready = 1'b0; dmem_rdata = 32'h12345678;
    cycle("rw.wait", 1'b1, 1'b1, wrec(1'b0, 1'b0, 5'd0, 32'h0));
    rst_n = 1'b0;
    #1;
    chk("rw.dmem_req", 64'(dmem_req), 64'd0);
    chk("rw.stallM", 64'(stallM), 64'd0);
    dmem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rw.W", 64'({misalignW, regwriteW, rdW, resultW}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LBU at 0x001 right after release
    set_op(1'b1, 1'b0, 2'b00, 3'b100, 5'd9, 32'h001, 32'h0, 32'h0);
    dmem_ready = 1'b1; dmem_rdata = 32'h0000FF00;
    cycle("lbu", 1'b0, 1'b1, wrec(1'b0, 1'b1, 5'd9, 32'h000000FF));

    // LH sign extension at 0x102, one wait state
    set_op(1'b1, 1'b0, 2'b00, 3'b001, 5'd10, 32'h102, 32'h0, 32'h0);
    dmem_ready = 1'b0; dmem_rdata = 32'h8001_0000;
    cycle("lh.w1", 1'b1, 1'b1, wrec(1'b0, 1'b0, 5'd0, 32'h0));
    dmem_ready = 1'b1;
    cycle("lh.done", 1'b0, 1'b1, wrec(1'b0, 1'b1, 5'd10, 32'hFFFF8001));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (async active-low reset).
REQ-002 The block SHALL have these control inputs from the EX/MEM register:
- regwriteM input 1: register write enable.
- memrwM input 1: 1 = store.
- wbselM input 2: 00 = memory, 01 = ALU, 10 = pc+4.
- funct3M input 3: access size/sign.
- rdM input 5: destination register.
REQ-003 The block SHALL have these data inputs: ALUresM input 32 (address/ALU result); data_writeM input 32 (store data); pc4M input 32 (pc+4).
REQ-004 The block SHALL have these data-memory port signals:
- dmem_req output 1; dmem_we output 1.
- dmem_addr output 32, word-aligned, {ALUresM[31:2],2'b00}.
- dmem_wdata output 32; dmem_wstrb output 4.
- dmem_rdata input 32; dmem_ready input 1.
REQ-005 The block SHALL have these outputs: stallM output 1 (hold upstream stages); regwriteW output 1; rdW output 5; resultW output 32 (write-back value); misalignW output 1 (misaligned access flag).

Function
REQ-006 An access SHALL be a load (wbselM==00, memrwM==0) or a store (memrwM==1); anything else is a non-memory op.
REQ-007 The FSM SHALL have two states: IDLE and WAIT.
REQ-008 In IDLE with an aligned access:
- dmem_req=1 combinationally in the same cycle.
- dmem_we=memrwM.
REQ-009 In IDLE, if dmem_ready=1 in the same cycle, the access SHALL complete with zero wait states and the FSM SHALL stay in IDLE.
REQ-010 In IDLE, if dmem_ready=0, the FSM SHALL go to WAIT. stallM=1 combinationally from that cycle until the completing cycle.
REQ-011 In WAIT, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb SHALL stay asserted and unchanged. The upstream holds all M inputs stable while stallM=1.
REQ-012 In WAIT, dmem_ready=1 SHALL complete the access, set stallM=0 in that cycle, and return the FSM to IDLE on the next edge.
REQ-013 Non-memory ops SHALL never assert dmem_req or stallM.
REQ-014 Store strobes and data SHALL be, with off=ALUresM[1:0]:
- SB (000): wstrb=0001<<off, wdata={4{data_writeM[7:0]}}.
- SH (001): wstrb=0011<<off, wdata={2{data_writeM[15:0]}}.
- SW (010): wstrb=1111, wdata=data_writeM.
REQ-015 Load data SHALL be selected from dmem_rdata by off and extended:
- LB (000): sign-extended byte; LBU (100): zero-extended byte.
- LH (001): sign-extended halfword; LHU (101): zero-extended halfword.
- LW (010): full word.
REQ-016 Other funct3 on a load SHALL return 0. Other funct3 on a store SHALL give wstrb=0000 with the handshake still performed.
REQ-017 An access SHALL be misaligned if it is LH/LHU/SH with off[0]=1, or LW/SW with off!=00.
REQ-018 A misaligned access SHALL:
- issue no dmem_req and no stall;
- set misalignW=1 for one cycle at the next edge;
- force regwriteW=0 at that edge.
REQ-019 The MEM/WB register SHALL update on every rising edge:
- When the M op completes (non-memory, misaligned, or ready received): capture regwriteW=regwriteM (0 if misaligned), rdW=rdM, and resultW from the wbselM mux.
- wbselM mux: 00 = extended load data, 01 = ALUresM, 10 = pc4M, 11 = 0.
- While stallM=1: insert a bubble (regwriteW=0, rdW=0, resultW=0, misalignW=0).
REQ-020 The write-back latency SHALL be one cycle after the completing cycle.
REQ-021 A dmem_ready input arriving while the FSM is in IDLE with no access SHALL be ignored.

Reset
REQ-022 While rst_n=0:
- FSM = IDLE.
- regwriteW=0, rdW=0, resultW=0, misalignW=0.
- dmem_req=0, stallM=0.
REQ-023 Reset asserted during WAIT SHALL abandon the access immediately, dropping dmem_req. The pending load result SHALL not be written.
REQ-024 After rst_n deasserts, the block SHALL accept a new access on the first rising edge.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Zero-wait LW: ALUresM=0x100, ready=1, rdata=0xDEADBEEF, rdM=5 -> next edge regwriteW=1, rdW=5, resultW=0xDEADBEEF, stallM never 1.
- LB with 2 wait cycles: ALUresM=0x103, rdata=0x80000000, ready on the 3rd cycle -> stallM=1 for 2 cycles, bubbles in W during the stall, then resultW=0xFFFFFF80.
- SH: ALUresM=0x202, data_writeM=0x1234ABCD, zero-wait -> wstrb=1100, wdata=0xABCDABCD, dmem_we=1, addr=0x200.
- Misaligned LW at 0x101 -> dmem_req=0, misalignW=1 for one cycle, regwriteW=0.
- ALU op (wbselM=01, ALUresM=7, rdM=3) and JAL (wbselM=10, pc4M=0x44) -> resultW=7 then 0x44, no dmem_req.
- rst_n pulsed low during WAIT -> dmem_req=0 and stallM=0 immediately; after release, a LBU at 0x001 with rdata=0x0000FF00 -> 0x000000FF.
